cam_init_sequencer: RTL and testbench
=====================================

CAM_INIT_SEQUENCER -- requirements
Module: cam_init_sequencer

Interface
REQ-001 Parameters SHALL be:
  - CLK_FREQ, default 100_000_000, system clock in Hz.
  - DEV_ADDR, default 7'h21, 7-bit I2C slave address.
  - GAP_CYCLES, default 1000, idle cycles between writes.
  - DELAY_MS, default 10, duration of a delay command in ms.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk  in  1  clock.
  - resetn  in  1  asynchronous active-low reset.
  - go  in  1  level; sampled in IDLE/DONE; starts or restarts the sequence.
  - rom_addr  out  8  table index.
  - rom_data  in  16  {reg_addr[15:8], reg_data[7:0]}; combinational, valid same cycle.
  - i2c_start  out  1  one-cycle write request to the I2C master.
  - i2c_busy  in  1  I2C master busy.
  - i2c_addr  out  7  slave address.
  - i2c_reg_addr  out  8  register address.
  - i2c_reg_data  out  8  register data.
  - active  out  1  sequence in progress.
  - done  out  1  sequence completed.
  - error  out  1  handshake timeout occurred.
REQ-003 Clock and reset: one clock, clk; reset resetn is asynchronous, active-low.

Function
REQ-004 States SHALL be: IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, GAP, DELAY, DONE.
REQ-005 IDLE: go=1 SHALL move to FETCH, with rom_addr<=0, done<=0, error<=0, active<=1.
REQ-006 FETCH: rom_data=16'hFFFF (end marker) SHALL move to DONE; rom_data=16'hFFF0 (delay command) SHALL move to DELAY; any other value SHALL latch i2c_reg_addr/i2c_reg_data from rom_data and move to ISSUE.
REQ-007 ISSUE SHALL assert i2c_start for exactly one cycle, then move to WAIT_HI.
REQ-008 WAIT_HI: i2c_busy=1 SHALL move to WAIT_LO; if busy is not seen within 8 cycles after the i2c_start pulse, set error=1 and move to DONE.
REQ-009 WAIT_LO: i2c_busy=0 SHALL move to GAP; there is no timeout in this state.
REQ-010 GAP SHALL count GAP_CYCLES cycles, then increment rom_addr and move to FETCH.
REQ-011 DELAY SHALL count CLK_FREQ/1000*DELAY_MS cycles, then increment rom_addr and move to FETCH; the counter SHALL be at least 32 bits wide.
REQ-012 DONE SHALL hold done=1 and active=0; go=1 restarts per REQ-005, clearing done and error.
REQ-013 i2c_addr SHALL equal DEV_ADDR at all times; i2c_reg_addr/i2c_reg_data SHALL stay stable from ISSUE until WAIT_LO exits.
REQ-014 rom_addr wrap: an increment from 8'hFF SHALL instead go to DONE with error=1 (missing end marker).
REQ-015 go asserted while active SHALL be ignored; i2c_start SHALL never assert outside ISSUE.
REQ-016 Latency: go=1 in IDLE gives FETCH on the next cycle and i2c_start high 2 cycles after go is sampled.

Reset
REQ-017 On resetn=0, asynchronously: state=IDLE, rom_addr=0, i2c_start=0, i2c_reg_addr=0, i2c_reg_data=0, active=0, done=0, error=0, all counters=0.
REQ-018 A reset mid-transaction SHALL abort immediately with no further i2c_start; go after release restarts from entry 0.

Verification
REQ-019 Table {1280, 1204, FFFF}, busy model high 1 cycle after start for 50 cycles -> exactly 2 start pulses (reg/data 12/80 then 12/04, addr 21), then done=1, error=0.
REQ-020 Table {FFF0, 3A04, FFFF}, DELAY_MS=1, CLK_FREQ=1_000_000 -> first start is at least 1000 cycles after go; done=1.
REQ-021 i2c_busy tied 0 -> error=1 and done=1 exactly 9 cycles after the start pulse; no second start.
REQ-022 resetn pulsed low during WAIT_LO -> outputs reach reset values in the same cycle; the next go fetches entry 0.
REQ-023 Table with no FFFF (all 1111) -> 256 writes, then error=1, done=1.
REQ-024 go held high through the whole sequence and into DONE -> a second full sequence starts one cycle after done asserts; done clears.

Source files
------------

// File: rtl/cam_init_sequencer.sv
// Walks a register table (end marker 16'hFFFF, delay command 16'hFFF0) and
// issues one I2C write per entry through a start/busy handshake.
module cam_init_sequencer #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter logic [6:0]  DEV_ADDR   = 7'h21,
  parameter int unsigned GAP_CYCLES = 1000,
  parameter int unsigned DELAY_MS   = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        go,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        i2c_start,
  input  logic        i2c_busy,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_reg_data,
  output logic        active,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] END_MARK  = 16'hFFFF;
  localparam logic [15:0] DELAY_CMD = 16'hFFF0;
  localparam int unsigned DELAY_RAW = (CLK_FREQ / 32'd1000) * DELAY_MS;
  // Zero-length waits still occupy one cycle so the compare never underflows.
  localparam logic [31:0] GAP_LIM   = (GAP_CYCLES == 32'd0) ? 32'd1 : 32'(GAP_CYCLES);
  localparam logic [31:0] DELAY_LIM = (DELAY_RAW == 32'd0) ? 32'd1 : 32'(DELAY_RAW);
  localparam logic [31:0] HI_LIM    = 32'd8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_GAP     = 3'd5,
    S_DELAY   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [7:0]  r_rom_addr;
  logic [7:0]  r_reg_addr;
  logic [7:0]  r_reg_data;
  logic        r_start;
  logic        r_active;
  logic        r_done;
  logic        r_error;

  state_t      w_state_nxt;
  logic [31:0] w_cnt_nxt;
  logic [7:0]  w_rom_addr_nxt;
  logic [7:0]  w_reg_addr_nxt;
  logic [7:0]  w_reg_data_nxt;
  logic        w_start_nxt;
  logic        w_active_nxt;
  logic        w_done_nxt;
  logic        w_error_nxt;
  logic [31:0] w_lim;

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = 32'd0;
    w_rom_addr_nxt = r_rom_addr;
    w_reg_addr_nxt = r_reg_addr;
    w_reg_data_nxt = r_reg_data;
    w_start_nxt    = 1'b0;
    w_active_nxt   = r_active;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    w_lim          = (r_state == S_GAP) ? GAP_LIM : DELAY_LIM;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (go) begin
          w_state_nxt    = S_FETCH;
          w_rom_addr_nxt = 8'd0;
          w_done_nxt     = 1'b0;
          w_error_nxt    = 1'b0;
          w_active_nxt   = 1'b1;
        end else begin
          w_state_nxt    = r_state;
        end
      end

      S_FETCH: begin
        if (rom_data == END_MARK) begin
          w_state_nxt  = S_DONE;
          w_done_nxt   = 1'b1;
          w_active_nxt = 1'b0;
        end else if (rom_data == DELAY_CMD) begin
          w_state_nxt  = S_DELAY;
        end else begin
          w_state_nxt    = S_ISSUE;
          w_reg_addr_nxt = rom_data[15:8];
          w_reg_data_nxt = rom_data[7:0];
          w_start_nxt    = 1'b1;
        end
      end

      S_ISSUE: begin
        w_state_nxt = S_WAIT_HI;
      end

      S_WAIT_HI: begin
        if (i2c_busy) begin
          w_state_nxt  = S_WAIT_LO;
        end else if (r_cnt == HI_LIM - 32'd1) begin
          w_state_nxt  = S_DONE;
          w_error_nxt  = 1'b1;
          w_done_nxt   = 1'b1;
          w_active_nxt = 1'b0;
        end else begin
          w_cnt_nxt    = r_cnt + 32'd1;
        end
      end

      S_WAIT_LO: begin
        if (!i2c_busy) begin
          w_state_nxt = S_GAP;
        end else begin
          w_state_nxt = S_WAIT_LO;
        end
      end

      // GAP and DELAY share the counter; only the terminal count differs.
      S_GAP, S_DELAY: begin
        if (r_cnt != w_lim - 32'd1) begin
          w_cnt_nxt      = r_cnt + 32'd1;
        end else if (r_rom_addr == 8'hFF) begin
          w_state_nxt    = S_DONE;
          w_error_nxt    = 1'b1;
          w_done_nxt     = 1'b1;
          w_active_nxt   = 1'b0;
        end else begin
          w_state_nxt    = S_FETCH;
          w_rom_addr_nxt = r_rom_addr + 8'd1;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= 32'd0;
      r_rom_addr <= 8'd0;
      r_reg_addr <= 8'd0;
      r_reg_data <= 8'd0;
      r_start    <= 1'b0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_reg_addr <= w_reg_addr_nxt;
      r_reg_data <= w_reg_data_nxt;
      r_start    <= w_start_nxt;
      r_active   <= w_active_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign rom_addr     = r_rom_addr;
  assign i2c_start    = r_start;
  assign i2c_addr     = DEV_ADDR;
  assign i2c_reg_addr = r_reg_addr;
  assign i2c_reg_data = r_reg_data;
  assign active       = r_active;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Self-checking bench for cam_init_sequencer: table-driven sequences plus
// hand-written latency, timeout, reset, wrap and held-go cases.
module tb_cam_init_sequencer;

  localparam int BUSY_LEN = 50;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        i2c_start;
  logic        i2c_busy;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_reg_addr;
  logic [7:0]  i2c_reg_data;
  logic        active;
  logic        done;
  logic        error;

  logic [15:0] rom [256];
  logic        busy_en = 1'b0;
  int          busy_cnt = 0;
  int          cyc = 0;
  int          start_total = 0;
  int          bad_addr = 0;
  logic [7:0]  log_ra [1024];
  logic [7:0]  log_rd [1024];
  int          log_cyc [1024];
  int          n_checks = 0;
  int          n_fail = 0;
  int          go_cyc = 0;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        busy_on;
    int          exp_starts;
    logic [7:0]  ra0;
    logic [7:0]  rd0;
    logic [7:0]  ra1;
    logic [7:0]  rd1;
    logic        exp_err;
    int          min_lat;
  } vec_t;

  vec_t vt [5];

  cam_init_sequencer #(
    .CLK_FREQ   (1_000_000),
    .DEV_ADDR   (7'h21),
    .GAP_CYCLES (4),
    .DELAY_MS   (1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .go           (go),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .i2c_start    (i2c_start),
    .i2c_busy     (i2c_busy),
    .i2c_addr     (i2c_addr),
    .i2c_reg_addr (i2c_reg_addr),
    .i2c_reg_data (i2c_reg_data),
    .active       (active),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];
  assign i2c_busy = (busy_cnt != 0);

  // I2C master model: busy rises the cycle after a start and lasts BUSY_LEN cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy_en && i2c_start) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (i2c_start === 1'b1) begin
      if (start_total < 1024) begin
        log_ra[start_total]  <= i2c_reg_addr;
        log_rd[start_total]  <= i2c_reg_data;
        log_cyc[start_total] <= cyc;
      end
      if (i2c_addr !== 7'h21) bad_addr <= bad_addr + 1;
      start_total <= start_total + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = e0;
    rom[1] = e1;
    rom[2] = e2;
  endtask

  task automatic go_pulse();
    @(negedge clk);
    go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    int base;
    int snap;
    int k;

    vt[0] = '{16'h1280, 16'h1204, 16'hFFFF, 1'b1, 2, 8'h12, 8'h80, 8'h12, 8'h04, 1'b0, 0};
    vt[1] = '{16'hFFF0, 16'h3A04, 16'hFFFF, 1'b1, 1, 8'h3A, 8'h04, 8'h00, 8'h00, 1'b0, 1000};
    vt[2] = '{16'h5501, 16'hFFFF, 16'hFFFF, 1'b0, 1, 8'h55, 8'h01, 8'h00, 8'h00, 1'b1, 0};
    vt[3] = '{16'hFFFF, 16'h1111, 16'hFFFF, 1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0};
    vt[4] = '{16'hFFF0, 16'hFFFF, 16'hFFFF, 1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0};

    load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_start", 32'(i2c_start), 32'd0);
    check("rst_reg_addr", 32'(i2c_reg_addr), 32'd0);
    check("rst_reg_data", 32'(i2c_reg_data), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_dev_addr", 32'(i2c_addr), 32'h21);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      load_rom(vt[v].e0, vt[v].e1, vt[v].e2);
      busy_en = vt[v].busy_on;
      base = start_total;
      go_pulse();
      wait_done(3000, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_error", v), 32'(error), 32'(vt[v].exp_err));
      check($sformatf("vec%0d_active", v), 32'(active), 32'd0);
      check($sformatf("vec%0d_starts", v), 32'(start_total - base), 32'(vt[v].exp_starts));
      if (vt[v].exp_starts > 0) begin
        check($sformatf("vec%0d_ra0", v), 32'(log_ra[base]), 32'(vt[v].ra0));
        check($sformatf("vec%0d_rd0", v), 32'(log_rd[base]), 32'(vt[v].rd0));
      end
      if (vt[v].exp_starts > 1) begin
        check($sformatf("vec%0d_ra1", v), 32'(log_ra[base + 1]), 32'(vt[v].ra1));
        check($sformatf("vec%0d_rd1", v), 32'(log_rd[base + 1]), 32'(vt[v].rd1));
      end
      if (vt[v].min_lat > 0) begin
        check($sformatf("vec%0d_delay_lat_ok", v),
              32'((log_cyc[base] - go_cyc) >= vt[v].min_lat), 32'd1);
      end
    end

    // go-to-start latency and one-cycle start pulse
    load_rom(16'h1280, 16'h1204, 16'hFFFF);
    busy_en = 1'b1;
    go_pulse();
    check("lat_active", 32'(active), 32'd1);
    check("lat_done_clr", 32'(done), 32'd0);
    check("lat_start_c1", 32'(i2c_start), 32'd0);
    check("lat_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    check("lat_start_c2", 32'(i2c_start), 32'd1);
    check("lat_reg_addr", 32'(i2c_reg_addr), 32'h12);
    check("lat_reg_data", 32'(i2c_reg_data), 32'h80);
    @(negedge clk);
    check("lat_start_c3", 32'(i2c_start), 32'd0);
    check("lat_reg_stable", 32'({i2c_reg_addr, i2c_reg_data}), 32'h1280);
    wait_done(2000, "lat");
    check("lat_error", 32'(error), 32'd0);

    // handshake timeout with busy never asserted
    load_rom(16'h5501, 16'h1204, 16'hFFFF);
    busy_en = 1'b0;
    base = start_total;
    go_pulse();
    k = 0;
    while (i2c_start !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("to_start_seen", 32'(i2c_start), 32'd1);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("to_latency", 32'(k), 32'd9);
    check("to_error", 32'(error), 32'd1);
    repeat (5) @(negedge clk);
    check("to_single_start", 32'(start_total - base), 32'd1);

    // reset while waiting for busy to drop
    load_rom(16'h1280, 16'h1204, 16'hFFFF);
    busy_en = 1'b1;
    go_pulse();
    k = 0;
    while (i2c_start !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("mid_rst_start", 32'(i2c_start), 32'd0);
    check("mid_rst_reg", 32'({i2c_reg_addr, i2c_reg_data}), 32'd0);
    check("mid_rst_flags", 32'({active, done, error}), 32'd0);
    snap = start_total;
    repeat (3) @(negedge clk);
    k = 0;
    while (i2c_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("mid_rst_no_start", 32'(start_total - snap), 32'd0);
    resetn = 1'b1;
    base = start_total;
    go_pulse();
    check("rst_restart_addr", 32'(rom_addr), 32'd0);
    wait_done(2000, "rst_restart");
    check("rst_restart_starts", 32'(start_total - base), 32'd2);
    check("rst_restart_first", 32'({log_ra[base], log_rd[base]}), 32'h1280);
    check("rst_restart_error", 32'(error), 32'd0);

    // go held high across done restarts immediately
    load_rom(16'h1280, 16'hFFFF, 16'hFFFF);
    base = start_total;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    wait_done(2000, "hold1");
    check("hold1_starts", 32'(start_total - base), 32'd1);
    check("hold1_error", 32'(error), 32'd0);
    @(negedge clk);
    check("hold_done_clr", 32'(done), 32'd0);
    check("hold_active", 32'(active), 32'd1);
    go = 1'b0;
    wait_done(2000, "hold2");
    check("hold2_starts", 32'(start_total - base), 32'd2);

    // table without end marker
    for (int i = 0; i < 256; i++) rom[i] = 16'h1111;
    busy_en = 1'b1;
    base = start_total;
    go_pulse();
    wait_done(20000, "wrap");
    check("wrap_starts", 32'(start_total - base), 32'd256);
    check("wrap_error", 32'(error), 32'd1);
    check("wrap_active", 32'(active), 32'd0);
    check("wrap_rom_addr", 32'(rom_addr), 32'hFF);

    @(negedge clk);
    check("dev_addr_on_starts", 32'(bad_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
